// File: rtl/axi_rd_pkg.sv
// axi_rd_pkg: shared AXI read constants, FSM states and size helper
package axi_rd_pkg;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam int AXI_4KB = 4096;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/axi_burst_calc.sv
// axi_burst_calc: beats for the next INCR burst, clipped at the 4 KB page, and the address after it
module axi_burst_calc import axi_rd_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int MAX_BURST_BEATS = 16,
  parameter int BPB = 4
)(
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       rem_beats,
  output logic [8:0]        beats,
  output logic [ADDR_W-1:0] next_addr
);
  localparam int BSH = log2(BPB);
  logic [31:0] to_4k, lim, b;
  // smallest of remaining beats, burst cap and beats left in the page
  always_comb begin
    to_4k = (32'(AXI_4KB) - 32'(addr[11:0])) >> BSH;
    lim = rem_beats < 32'(MAX_BURST_BEATS) ? rem_beats : 32'(MAX_BURST_BEATS);
    b = lim < to_4k ? lim : to_4k;
    beats = b[8:0];
    next_addr = addr + (ADDR_W'(b) << BSH);
  end
endmodule

// File: rtl/axi_read_master_mo.sv
// axi_read_master_mo: multi-outstanding AXI4 read master with FIFO credit flow control
module axi_read_master_mo import axi_rd_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_BURST_BEATS = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int SPACE_W = 11
)(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_src_addr,
  input  logic [31:0]       i_total_len,
  output logic              o_busy,
  output logic              o_read_done,
  output logic              o_error,
  input  logic [SPACE_W-1:0] i_fifo_space,
  output logic              o_fifo_push,
  output logic [DATA_W-1:0] o_r_data,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready
);
  localparam int BPB = DATA_W / 8;
  localparam int BSH = log2(BPB);
  localparam int CW = ((SPACE_W > 9) ? SPACE_W : 9) + 2;

  state_t state, state_n;
  logic [ADDR_W-1:0] addr, calc_addr, next_addr;
  logic [31:0] rem_beats, start_rem, calc_rem;
  logic [8:0] beats;
  logic [4:0] outstanding;
  logic [CW-1:0] reserved;
  logic bad, go, ar_hs, rlast_hs, can_issue, all_issued, fin;

  assign bad = ((i_src_addr & ADDR_W'(BPB - 1)) != '0) || ((i_total_len & 32'(BPB - 1)) != '0);
  assign start_rem = bad ? '0 : i_total_len >> BSH;
  assign go = state == S_IDLE && i_start;
  // in IDLE the first burst is sized straight from the request so arvalid can rise the next cycle
  assign calc_addr = state == S_IDLE ? i_src_addr : addr;
  assign calc_rem = state == S_IDLE ? start_rem : rem_beats;
  assign ar_hs = m_axi_arvalid && m_axi_arready;
  assign m_axi_rready = o_busy;
  assign o_fifo_push = m_axi_rvalid && m_axi_rready;
  assign o_r_data = m_axi_rdata;
  assign rlast_hs = o_fifo_push && m_axi_rlast;
  assign can_issue = (go || state == S_ISSUE) && !m_axi_arvalid && calc_rem != '0 &&
                     outstanding < 5'(MAX_OUTSTANDING) && CW'(i_fifo_space) >= reserved + CW'(beats);
  assign all_issued = rem_beats == '0 && !m_axi_arvalid;
  assign fin = outstanding == '0 || (outstanding == 5'd1 && rlast_hs);
  assign o_busy = state == S_ISSUE || state == S_DRAIN;
  assign o_read_done = state == S_DONE;
  assign m_axi_arsize = 3'(BSH);
  assign m_axi_arburst = AXI_BURST_INCR;

  axi_burst_calc #(.ADDR_W(ADDR_W), .MAX_BURST_BEATS(MAX_BURST_BEATS), .BPB(BPB)) u_calc (
    .addr(calc_addr),
    .rem_beats(calc_rem),
    .beats(beats),
    .next_addr(next_addr)
  );

  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= state_n;

  // next state: finish once every AR is out and the last RLAST has been taken
  always_comb begin
    state_n = state;
    state_n = state == S_IDLE ? (i_start ? S_ISSUE : S_IDLE) :
              state == S_ISSUE ? (all_issued ? (fin ? S_DONE : S_DRAIN) : S_ISSUE) :
              state == S_DRAIN ? (fin ? S_DONE : S_DRAIN) : S_IDLE;
  end

  // burst bookkeeping, AR channel registers, credit and error tracking
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      addr <= '0;
      rem_beats <= '0;
      outstanding <= '0;
      reserved <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr <= '0;
      m_axi_arlen <= '0;
      o_error <= 1'b0;
    end else begin
      if (go) begin
        addr <= i_src_addr;
        rem_beats <= start_rem;
      end else if (ar_hs) begin
        addr <= next_addr;
        rem_beats <= rem_beats - 32'(beats);
      end
      if (go) o_error <= bad;
      else if (o_fifo_push && m_axi_rresp != AXI_RESP_OKAY) o_error <= 1'b1;
      if (can_issue) begin
        m_axi_arvalid <= 1'b1;
        m_axi_araddr <= calc_addr;
        m_axi_arlen <= 8'(beats - 9'd1);
      end else if (ar_hs) m_axi_arvalid <= 1'b0;
      outstanding <= outstanding + 5'(ar_hs) - 5'(rlast_hs);
      reserved <= reserved + (ar_hs ? CW'(beats) : CW'(0)) - CW'(o_fifo_push);
    end
endmodule

// File: tb/tb_axi_read_master_mo.sv
// tb_axi_read_master_mo: randomized scoreboard bench with an AXI slave and FIFO model
module tb_axi_read_master_mo;
  localparam int AW = 32, DW = 32, MB = 16, MO = 4, SW = 11, BPB = DW / 8;

  logic clk = 0, reset_n = 0, i_start = 0;
  logic [AW-1:0] i_src_addr = 0;
  logic [31:0] i_total_len = 0;
  logic o_busy, o_read_done, o_error, o_fifo_push;
  logic [SW-1:0] i_fifo_space = 0;
  logic [DW-1:0] o_r_data, m_axi_rdata = 0;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0] m_axi_arlen;
  logic [2:0] m_axi_arsize;
  logic [1:0] m_axi_arburst, m_axi_rresp = 0;
  logic m_axi_arvalid, m_axi_arready = 0, m_axi_rlast = 0, m_axi_rvalid = 0, m_axi_rready;

  axi_read_master_mo #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST_BEATS(MB), .MAX_OUTSTANDING(MO), .SPACE_W(SW)) dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_src_addr(i_src_addr), .i_total_len(i_total_len),
    .o_busy(o_busy), .o_read_done(o_read_done), .o_error(o_error), .i_fifo_space(i_fifo_space),
    .o_fifo_push(o_fifo_push), .o_r_data(o_r_data), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_ar_addr[$], exp_data[$], sq_addr[$];
  int exp_ar_len[$], sq_len[$];
  int vectors = 0, miscompares = 0;
  int cap = 1024, occ = 0, beat = 0, ar_pct = 100, r_pct = 100;
  bit drain_en = 1, r_en = 1, err_en = 0, any_err = 0, exp_bad = 0, exp_beats = 0;
  int start_cyc = 0, last_rlast = 0, ar_count = 0, push_count = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // reference: split the request into page-safe bursts and list every beat address
  task automatic model(input logic [31:0] a0, input int len);
    logic [31:0] a;
    int r, chunk, room;
    a = a0;
    r = len;
    exp_bad = (a0 % BPB != 0) || (len % BPB != 0);
    exp_beats = !exp_bad && len > 0;
    if (exp_beats)
      while (r > 0) begin
        room = 4096 - int'(a[11:0]);
        chunk = r;
        if (chunk > MB * BPB) chunk = MB * BPB;
        if (chunk > room) chunk = room;
        exp_ar_addr.push_back(a);
        exp_ar_len.push_back(chunk / BPB - 1);
        for (int i = 0; i < chunk / BPB; i++) exp_data.push_back(a + 32'(i * BPB));
        a = a + 32'(chunk);
        r = r - chunk;
      end
  endtask

  task automatic start(input logic [31:0] a, input int len);
    @(posedge clk); #1;
    i_start = 1; i_src_addr = a; i_total_len = len; any_err = 0;
    model(a, len);
    @(negedge clk); start_cyc = cyc;
    @(posedge clk); #1;
    i_start = 0;
    @(negedge clk);
    check("busy_after_start", o_busy, 1);
  endtask

  task automatic wait_done(input int lim);
    int n;
    n = 0;
    while (!o_read_done && n < lim) begin @(negedge clk); n++; end
    if (n >= lim) check("done_timeout", o_read_done, 1);
  endtask

  task automatic wait_cond_pushes(input int target, input int lim);
    int n;
    n = 0;
    while (push_count < target && n < lim) begin @(negedge clk); n++; end
    if (n >= lim) check("push_timeout", 32'(push_count), 32'(target));
  endtask

  // AXI slave returning beat address as data, plus the downstream FIFO occupancy
  initial begin
    bit s_ar, s_r, s_push;
    logic [31:0] s_addr;
    int s_len;
    forever begin
      @(negedge clk);
      s_ar = m_axi_arvalid && m_axi_arready;
      s_addr = m_axi_araddr;
      s_len = int'(m_axi_arlen);
      s_r = m_axi_rvalid && m_axi_rready;
      s_push = o_fifo_push;
      @(posedge clk); #1;
      if (!reset_n) begin
        sq_addr.delete(); sq_len.delete();
        beat = 0; occ = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
      end else begin
        if (s_ar) begin sq_addr.push_back(s_addr); sq_len.push_back(s_len); end
        if (s_r) begin
          if (beat == sq_len[0]) begin void'(sq_addr.pop_front()); void'(sq_len.pop_front()); beat = 0; end
          else beat++;
        end
        if (s_push) occ++;
        if (drain_en && occ > 0 && $urandom_range(1) == 1) occ--;
        m_axi_arready = $urandom_range(99) < ar_pct;
        if (s_r || !m_axi_rvalid) begin
          if (r_en && sq_len.size() > 0 && $urandom_range(99) < r_pct) begin
            m_axi_rvalid = 1;
            m_axi_rdata = sq_addr[0] + 32'(beat * BPB);
            m_axi_rlast = beat == sq_len[0];
            m_axi_rresp = (err_en && $urandom_range(7) == 0) ? 2'b10 : 2'b00;
            if (m_axi_rresp != 0) any_err = 1;
          end else m_axi_rvalid = 0;
        end
      end
      i_fifo_space = SW'(cap > occ ? cap - occ : 0);
    end
  end

  // monitor: pops expected ARs, beats and completions as the DUT presents them
  initial begin
    bit ar_wait, prev_done;
    logic [31:0] p_addr;
    logic [7:0] p_len;
    ar_wait = 0; prev_done = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin ar_wait = 0; prev_done = 0; end
      else begin
        if (ar_wait) begin
          check("ar_hold_valid", m_axi_arvalid, 1);
          check("ar_hold_addr", m_axi_araddr, p_addr);
          check("ar_hold_len", m_axi_arlen, p_len);
        end
        if (m_axi_arvalid && exp_ar_addr.size() == 0) check("ar_unexpected", m_axi_araddr, 32'hFFFF_FFFF);
        else if (m_axi_arvalid && m_axi_arready) begin
          check("araddr", m_axi_araddr, exp_ar_addr.pop_front());
          check("arlen", m_axi_arlen, 8'(exp_ar_len.pop_front()));
          check("arsize", m_axi_arsize, 3'd2);
          check("arburst", m_axi_arburst, 2'b01);
          check("outstanding_limit", sq_len.size() < MO, 1);
          ar_count++;
        end
        ar_wait = m_axi_arvalid && !m_axi_arready;
        p_addr = m_axi_araddr;
        p_len = m_axi_arlen;
        if (o_fifo_push) begin
          if (exp_data.size() == 0) check("push_unexpected", o_r_data, 32'hFFFF_FFFF);
          else check("push_data", o_r_data, exp_data.pop_front());
          check("fifo_room", i_fifo_space != 0, 1);
          push_count++;
          if (m_axi_rlast) last_rlast = cyc;
        end
        if (o_read_done) begin
          check("done_pulse_width", prev_done, 0);
          check("busy_at_done", o_busy, 0);
          check("done_error", o_error, exp_bad | any_err);
          check("ars_left", 32'(exp_ar_addr.size()), 0);
          check("beats_left", 32'(exp_data.size()), 0);
          if (exp_beats) check("done_after_rlast", 32'(cyc), 32'(last_rlast + 1));
          else check("done_latency", 32'(cyc), 32'(start_cyc + 2));
        end
        prev_done = o_read_done;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int len, base, n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", o_busy, 0);
    check("rst_arvalid", m_axi_arvalid, 0);
    check("rst_araddr", m_axi_araddr, 0);
    check("rst_arsize", m_axi_arsize, 3'd2);
    check("rst_arburst", m_axi_arburst, 2'b01);
    check("rst_done", o_read_done, 0);
    check("rst_error", o_error, 0);
    reset_n = 1;

    start(32'h4000, 64);
    check("arvalid_after_start", m_axi_arvalid, 1);
    wait_done(2000);

    r_en = 0; ar_pct = 50; base = ar_count;
    start(32'h4100, 256);
    n = 0;
    while (ar_count - base < 4 && n < 200) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    check("ars_before_r", 32'(ar_count - base), 4);
    check("outstanding_peak", 32'(sq_len.size()), 4);
    r_en = 1; ar_pct = 100;
    wait_done(2000);

    start(32'h4FF0, 64);
    wait_done(2000);

    n = 0;
    while (occ != 0 && n < 2000) begin @(negedge clk); n++; end
    drain_en = 0; cap = 20; base = ar_count;
    start(32'h6000, 128);
    wait_cond_pushes(push_count + 15, 500);
    repeat (10) @(negedge clk);
    check("ar_withheld", 32'(ar_count - base), 1);
    cap = 40;
    wait_done(2000);
    drain_en = 1; cap = 1024;

    err_en = 1;
    start(32'h7000, 256);
    wait_done(3000);
    err_en = 0;

    start(32'h4002, 64);
    check("misaligned_no_ar", m_axi_arvalid, 0);
    wait_done(20);

    start(32'h5000, 0);
    wait_done(20);

    start(32'h9000, 128);
    @(posedge clk); #1;
    i_start = 1; i_src_addr = 32'hA000; i_total_len = 64;
    @(posedge clk); #1;
    i_start = 0;
    wait_done(2000);

    for (int t = 0; t < 25; t++) begin
      a = 32'h1_0000 + 32'($urandom_range(7)) * 4096 +
          ($urandom_range(1) == 1 ? 32'(4096 - BPB * $urandom_range(1, 40)) : 32'(BPB * $urandom_range(0, 1023)));
      len = BPB * $urandom_range(0, 150);
      if ($urandom_range(7) == 0) a = a + 2;
      if ($urandom_range(9) == 0) len = len + 1;
      cap = $urandom_range(16, 64);
      ar_pct = $urandom_range(30, 100);
      r_pct = $urandom_range(30, 100);
      err_en = $urandom_range(1) == 1;
      start(a, len);
      wait_done(6000);
    end
    err_en = 0; ar_pct = 100; r_pct = 100; cap = 1024;

    start(32'h4000, 256);
    wait_cond_pushes(push_count + 5, 500);
    @(negedge clk); #2;
    reset_n = 0;
    exp_ar_addr.delete(); exp_ar_len.delete(); exp_data.delete();
    #1;
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_arvalid", m_axi_arvalid, 0);
    check("mid_rst_araddr", m_axi_araddr, 0);
    check("mid_rst_arlen", m_axi_arlen, 0);
    check("mid_rst_rready", m_axi_rready, 0);
    check("mid_rst_push", o_fifo_push, 0);
    check("mid_rst_error", o_error, 0);
    check("mid_rst_arsize", m_axi_arsize, 3'd2);
    repeat (3) @(negedge clk);
    reset_n = 1;
    cap = 16;
    start(32'h8000, 64);
    wait_done(2000);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axi_read_master_mo.md
# axi_read_master_mo

Parametrised AXI4 read master for the DMA datapath. It converts a (source address, byte length) request into INCR bursts that never cross a 4 KB boundary, keeps up to MAX_OUTSTANDING AR transactions in flight, and pushes returned beats into the downstream read FIFO. FIFO backpressure is handled by credit, using the FIFO's free-word count rather than a full flag. It is the multi-outstanding, width- and burst-generic successor of the single-outstanding 32-bit Read_Master in the Top_DMA path.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; one of 32, 64 or 128
- MAX_BURST_BEATS, 16, maximum beats per burst; power of 2, 1..256
- MAX_OUTSTANDING, 4, maximum ARs accepted but not yet completed by RLAST; 1..16
- SPACE_W, 11, width of i_fifo_space
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- i_start  in  1  request strobe; sampled only in IDLE
- i_src_addr  in  ADDR_W  start byte address
- i_total_len  in  32  byte count
- o_busy  out  1  high from accepted start until o_read_done
- o_read_done  out  1  one-cycle completion pulse
- o_error  out  1  sticky error flag; cleared by the next accepted start
- i_fifo_space  in  SPACE_W  free words in the downstream FIFO
- o_fifo_push  out  1  write strobe, equal to rvalid && rready
- o_r_data  out  DATA_W  equal to m_axi_rdata
- m_axi_araddr, m_axi_arlen[7:0], m_axi_arsize[2:0], m_axi_arburst[1:0], m_axi_arvalid  out; m_axi_arready  in
- m_axi_rdata[DATA_W], m_axi_rresp[1:0], m_axi_rlast, m_axi_rvalid  in; m_axi_rready  out

## Operation
- BPB = DATA_W/8 (bytes per beat).
- Misalignment check at start: if src_addr or total_len is not a multiple of BPB, set o_error, issue no AR, and pulse done.
- total_len = 0 → no AR; pulse done.
- States:
  - IDLE: on start, go to ISSUE.
  - ISSUE: issue ARs; when all ARs are issued, go to DRAIN.
  - DRAIN: wait for the final RLAST, then go to DONE.
  - DONE: pulse done for one cycle, then go to IDLE.
- Burst length: beats = min(rem_beats, MAX_BURST_BEATS, (4096 − addr[11:0])/BPB). Outputs are arlen = beats−1, arsize = log2(BPB), arburst = INCR (2'b01).
- AR issue condition: outstanding < MAX_OUTSTANDING and i_fifo_space ≥ reserved + beats.
  - reserved = beats granted but not yet pushed; it increments by beats on the AR handshake and decrements by 1 per push.
- On the AR handshake:
  - addr += beats·BPB
  - rem_beats −= beats
  - outstanding +1
- On an RLAST handshake, outstanding −1. Simultaneous AR and RLAST handshakes leave outstanding unchanged.
- reserved must be updated correctly when an AR handshake and a push happen in the same cycle.
- m_axi_rready = o_busy. The credit mechanism guarantees FIFO room for every beat.
- rresp ≠ OKAY sets o_error. The beat is still pushed and the transfer continues.
- i_start while busy is ignored.
- Reset mid-transfer returns to IDLE and clears all counters. Inflight R beats after reset are not the block's concern.

## Timing
- Reset values: all outputs 0, except arsize = log2(BPB) and arburst = 2'b01.
- Start accepted at cycle N → o_busy = 1 at N+1. If credit allows, arvalid = 1 at N+1.
- arvalid and araddr/arlen stay stable until arready. The next AR may assert in the cycle after a handshake, giving back-to-back ARs every 2 cycles minimum.
- Credit is evaluated combinationally before asserting arvalid. Credit is never re-checked while arvalid is held.
- o_fifo_push is combinational from rvalid && rready, with zero latency.
- o_read_done pulses the cycle after the final RLAST handshake. o_busy drops in the same cycle as done.
- Misaligned or zero-length requests: done at N+2.

## Structure
- Package axi_rd_pkg holds:
  - AXI_BURST_INCR, AXI_RESP_OKAY, AXI_4KB = 4096
  - the state enum
  - a log2 function for arsize
- Sub-module axi_burst_calc computes beats and next_addr from addr, rem_beats, MAX_BURST_BEATS and BPB, including the 4 KB clip. It is combinational and unit-tested separately.

## Test plan
- DATA_W=32, start at 0x4000 with 64 B, space=1024 → one AR (0x4000, arlen=15), 16 pushes of data 0x4000..0x403C, one done pulse.
- 0x4100, 256 B, slave arready delayed 2 cycles, rvalid delayed 8 cycles → 4 ARs (0x4100/0x4140/0x4180/0x41C0) all issued before the first R beat; outstanding peaks at 4.
- 0x4FF0, 64 B → AR 0x4FF0 arlen=3, then AR 0x5000 arlen=11; 16 pushes total.
- 0x6000, 128 B, space held at 20, then raised to 40 after 100 ns → first AR issued; second AR withheld until space ≥ reserved+16; no push ever exceeds space.
- DATA_W=64, 0x4000, 256 B → 2 ARs with arlen=15, arsize=3; SLVERR on beat 5 → o_error=1, all 32 beats still pushed, done pulses.
- Misaligned 0x4002 with 64 B → o_error=1 and done at N+2 with no arvalid; reset_n asserted mid-burst → all outputs at reset values and o_busy=0.
